alu_share_arbiter: RTL

//  Shares one 8-bit ALU core between two requesters. Arbitrates round-robin,

---
 rtl/alu_share_arbiter_if.sv | 65 ++++++
 rtl/alu_share_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_share_arbiter_if
//  Description : Bundle of the request, response and ALU-side signals of the
//                shared-ALU arbiter.
//                  slave  - arbiter view (takes requests, drives the ALU)
//                  master - environment view (requesters + ALU core)
//  Signals     : req0_*/req1_*  valid/ready handshake plus a, b, op
//                rsp_*          tagged one-cycle response (id/result/flags/err)
//                alu_*          operands/opcode/start out, done/result/flags in
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_share_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 3
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [OP_W-1:0]   req0_op;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [OP_W-1:0]   req1_op;

    logic              rsp_valid;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;
    logic              rsp_carry;
    logic              rsp_err;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic              alu_start;
    logic              alu_done;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              alu_carry;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_carry, rsp_err,
        output alu_a, alu_b, alu_op, alu_start,
        input  alu_done, alu_result, alu_zero, alu_carry
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_carry, rsp_err,
        input  alu_a, alu_b, alu_op, alu_start,
        output alu_done, alu_result, alu_zero, alu_carry
    );
endinterface
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_share_arbiter
//  Description : Shares one ALU core between two requesters. Round-robin
//                grant, operand latch, one-cycle start pulse, wait for done
//                with timeout, and a tagged one-cycle response.
//  Ports       : clk    - single rising-edge clock
//                reset  - synchronous, active-high
//                bus    - alu_share_arbiter_if.slave (requests, response, ALU)
//  Revision    : 1.0  initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int DATA_W  = 8,
    parameter int OP_W    = 3,
    parameter int TIMEOUT = 15
) (
    input  wire logic           clk,
    input  wire logic           reset,
    alu_share_arbiter_if.slave  bus
);

    localparam int                   c_TIMER_W   = $clog2(TIMEOUT + 1);
    localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic                 r_last_grant;
    logic                 r_id;
    logic [DATA_W-1:0]    r_a;
    logic [DATA_W-1:0]    r_b;
    logic [OP_W-1:0]      r_op;
    logic [c_TIMER_W-1:0] r_timer;

    logic                 r_rsp_id;
    logic [DATA_W-1:0]    r_rsp_result;
    logic                 r_rsp_zero;
    logic                 r_rsp_carry;
    logic                 r_rsp_err;

    logic                 w_grant_valid;
    logic                 w_grant_id;
    logic                 w_done;
    logic                 w_timeout;

    // ------------------------------------------------------------------------
    // Next-state / grant decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_grant_valid = 1'b0;
        w_grant_id    = 1'b0;
        w_done        = 1'b0;
        w_timeout     = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Ready is combinational, so it is held off while reset is
                // asserted to keep every output quiet during reset.
                if (!reset && (bus.req0_valid || bus.req1_valid)) begin
                    w_grant_valid = 1'b1;
                    if (bus.req0_valid && bus.req1_valid) begin
                        w_grant_id = ~r_last_grant;
                    end else begin
                        w_grant_id = bus.req1_valid;
                    end
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                // A done strobe in the final timer cycle still wins.
                if (bus.alu_done) begin
                    w_done       = 1'b1;
                    w_state_next = S_RESP;
                end else if (r_timer == c_TIMER_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State, operand latch, timer and response registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= '0;
            r_timer      <= '0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_carry  <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if (w_grant_valid) begin
                r_id <= w_grant_id;
                if (w_grant_id) begin
                    r_a  <= bus.req1_a;
                    r_b  <= bus.req1_b;
                    r_op <= bus.req1_op;
                end else begin
                    r_a  <= bus.req0_a;
                    r_b  <= bus.req0_b;
                    r_op <= bus.req0_op;
                end
            end

            // Cleared on every launch, so it never reaches TIMEOUT and
            // cannot wrap.
            if (r_state == S_ISSUE) begin
                r_timer <= '0;
            end else if (r_state == S_WAIT && !w_done && !w_timeout) begin
                r_timer <= r_timer + 1'b1;
            end

            // Response fields are loaded on the way into RESP and then held
            // until the next operation completes.
            if (w_done) begin
                r_rsp_id     <= r_id;
                r_rsp_result <= bus.alu_result;
                r_rsp_zero   <= bus.alu_zero;
                r_rsp_carry  <= bus.alu_carry;
                r_rsp_err    <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_id     <= r_id;
                r_rsp_result <= '0;
                r_rsp_zero   <= 1'b0;
                r_rsp_carry  <= 1'b0;
                r_rsp_err    <= 1'b1;
            end

            if (r_state == S_RESP) begin
                r_last_grant <= r_rsp_id;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.req0_ready = w_grant_valid && !w_grant_id;
    assign bus.req1_ready = w_grant_valid &&  w_grant_id;

    assign bus.alu_start  = (r_state == S_ISSUE);
    assign bus.alu_a      = r_a;
    assign bus.alu_b      = r_b;
    assign bus.alu_op     = r_op;

    assign bus.rsp_valid  = (r_state == S_RESP);
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_zero   = r_rsp_zero;
    assign bus.rsp_carry  = r_rsp_carry;
    assign bus.rsp_err    = r_rsp_err;

endmodule
`default_nettype wire
